// File: rtl/kb_event_queue.sv
// kb_event_queue: turns held-key ASCII levels into discrete key events with optional typematic repeat, queued in a FIFO for the CPU.
// Ports:
//   clk, rst_n        - system clock (CLOCK_50 domain), asynchronous active-low reset
//   kb_ascii, kb_flags - current key and {is_error, is_special, is_capital, is_ctrl, is_shift}
//   rd_en             - one-cycle pop strobe
//   rd_data, rd_valid - show-ahead head entry {3'b0, flags, ascii} (0 when empty), non-empty flag
//   fifo_count        - entries held
//   overflow, ovf_clr - sticky dropped-event flag and its clear (a drop wins over a clear)
//   irq               - pending-events interrupt, equal to rd_valid
// Build option: define KB_REPEAT_EN for IDLE/DELAY/REPEAT auto-repeat; otherwise IDLE/HELD, one event per press.
module kb_event_queue #(
    parameter int DELAY_CYC  = 25000000,
    parameter int REPEAT_CYC = 12500000,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        kb_ascii,
    input  logic [4:0]        kb_flags,
    input  logic              rd_en,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              irq
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    if (DELAY_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
        $error("kb_event_queue: DELAY_CYC and REPEAT_CYC must be at least 1");
    end

    logic [7:0]        a_q;
    logic              push;
    logic              key_nz;
    logic              key_chg;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [12:0]       mem [DEPTH];

    assign key_nz  = kb_ascii != 8'd0;
    assign key_chg = key_nz && kb_ascii != a_q;

`ifdef KB_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t      state;
    logic [31:0] timer;
    logic [31:0] lim;

    assign lim  = state == DELAY ? 32'(DELAY_CYC - 1) : 32'(REPEAT_CYC - 1);
    assign push = key_nz && (state == IDLE || key_chg || timer == lim);

    // A new press (from IDLE) and a key change both restart the initial delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else if (!key_nz) begin
            state <= IDLE;
            timer <= '0;
        end else if (state == IDLE || key_chg) begin
            state <= DELAY;
            timer <= '0;
        end else if (timer == lim) begin
            state <= REPEAT;
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    typedef enum logic {IDLE, HELD} state_t;
    state_t state;

    assign push = key_nz && (state == IDLE || key_chg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= key_nz ? HELD : IDLE;
    end
`endif

    // When full, a simultaneous pop frees the slot the push needs.
    assign do_pop  = rd_en && fifo_count != '0;
    assign do_push = push && (fifo_count != FULL || rd_en);
    assign drop    = push && fifo_count == FULL && !rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            a_q        <= kb_ascii;
            wr_ptr     <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + (ADDR_W + 1)'(do_push) - (ADDR_W + 1)'(do_pop);
            overflow   <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {kb_flags, kb_ascii};
    end

    assign rd_valid = fifo_count != '0;
    assign rd_data  = rd_valid ? {3'b000, mem[rd_ptr]} : 16'd0;
    assign irq      = rd_valid;
endmodule

// File: tb/tb_kb_event_queue.sv
// tb_kb_event_queue: directed table-driven and sequence checks for kb_event_queue.
module tb_kb_event_queue;
`ifdef KB_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  kb_ascii = '0;
    logic [4:0]  kb_flags = '0;
    logic        rd_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    kb_event_queue #(.DELAY_CYC(20), .REPEAT_CYC(8), .ADDR_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kb_ascii(kb_ascii),
        .kb_flags(kb_flags),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [4:0]  f;
        logic        rd;
        logic        clr;
        int          n;
        int          cnt;
        logic [15:0] data;
        logic        ovf;
    } vec_t;

    vec_t v[14];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int cnt, input int data, input int ovf);
        chk({nm, " count"}, int'(fifo_count), cnt);
        chk({nm, " data"}, int'(rd_data), data);
        chk({nm, " valid"}, int'(rd_valid), int'(cnt != 0));
        chk({nm, " irq"}, int'(irq), int'(cnt != 0));
        chk({nm, " ovf"}, int'(overflow), ovf);
    endtask

    initial begin
        v[0]  = '{8'h61, 5'h01, 1'b0, 1'b0, 10, 1, 16'h0161, 1'b0};
        v[1]  = '{8'h00, 5'h00, 1'b0, 1'b0, 3, 1, 16'h0161, 1'b0};
        v[2]  = '{8'h00, 5'h00, 1'b1, 1'b0, 1, 0, 16'h0000, 1'b0};
        v[3]  = '{8'h41, 5'h00, 1'b0, 1'b0, 45, REP ? 5 : 1, 16'h0041, 1'b0};
        v[4]  = '{8'h00, 5'h00, 1'b0, 1'b0, 2, REP ? 5 : 1, 16'h0041, 1'b0};
        v[5]  = '{8'h00, 5'h00, 1'b1, 1'b0, REP ? 5 : 1, 0, 16'h0000, 1'b0};
        v[6]  = '{8'h61, 5'h00, 1'b0, 1'b0, 5, 1, 16'h0061, 1'b0};
        v[7]  = '{8'h62, 5'h00, 1'b0, 1'b0, 25, REP ? 3 : 2, 16'h0061, 1'b0};
        v[8]  = '{8'h00, 5'h00, 1'b1, 1'b0, 1, REP ? 2 : 1, 16'h0062, 1'b0};
        v[9]  = '{8'h00, 5'h00, 1'b1, 1'b0, 1, REP ? 1 : 0, REP ? 16'h0062 : 16'h0000, 1'b0};
        v[10] = '{8'h00, 5'h00, 1'b1, 1'b0, 1, 0, 16'h0000, 1'b0};
        v[11] = '{8'h33, 5'h00, 1'b0, 1'b0, 3, 1, 16'h0033, 1'b0};
        v[12] = '{8'h33, 5'h02, 1'b0, 1'b0, 3, 1, 16'h0033, 1'b0};
        v[13] = '{8'h00, 5'h00, 1'b1, 1'b0, 1, 0, 16'h0000, 1'b0};

        step(2);
        chk_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        chk_all("idle", 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            kb_ascii = v[i].a;
            kb_flags = v[i].f;
            rd_en    = v[i].rd;
            ovf_clr  = v[i].clr;
            step(v[i].n);
            chk_all($sformatf("vec%0d", i), v[i].cnt, int'(v[i].data), int'(v[i].ovf));
        end
        rd_en = 1'b0;
        kb_flags = '0;

        for (int i = 0; i < 9; i++) begin
            kb_ascii = 8'h31 + 8'(i);
            step(1);
            kb_ascii = 8'h00;
            step(1);
        end
        chk_all("overflow", 8, 16'h0031, 1);
        kb_ascii = 8'h3A;
        ovf_clr = 1'b1;
        step(1);
        chk_all("drop_with_clr", 8, 16'h0031, 1);
        kb_ascii = 8'h00;
        step(1);
        chk_all("ovf_clr", 8, 16'h0031, 0);
        ovf_clr = 1'b0;
        kb_ascii = 8'h5A;
        rd_en = 1'b1;
        step(1);
        chk_all("full_push_pop", 8, 16'h0032, 0);
        kb_ascii = 8'h00;
        rd_en = 1'b0;
        step(1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), int'(rd_data), i < 7 ? 32'h32 + i : 32'h5A);
            rd_en = 1'b1;
            step(1);
            rd_en = 1'b0;
        end
        chk_all("drained", 0, 0, 0);

        kb_ascii = 8'h41;
        step(30);
        chk_all("pre_reset", REP ? 3 : 1, 16'h0041, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0);
        kb_ascii = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(5);
        chk_all("post_reset", 0, 0, 0);
        kb_ascii = 8'h41;
        step(45);
        chk_all("post_reset_hold", REP ? 5 : 1, 16'h0041, 0);
        kb_ascii = 8'h00;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
